// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - circular result buffer behind the ALU with edge-detected push/pop
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         ALUout,
    input  logic [2:0]               func,
    input  logic                     push,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [2:0]               head_func,
    output logic [WIDTH-1:0]         last_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH+2:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_d;
    logic             pop_d;
    logic             push_ev;
    logic             pop_ev;
    logic             push_ok;
    logic             pop_ok;

    assign push_ev = push & ~push_d;
    assign pop_ev  = pop & ~pop_d;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    // a push into a full queue still lands when the same edge frees the head slot
    assign push_ok = push_ev & (~full | pop_ev);
    assign pop_ok  = pop_ev & ~empty;

    assign head_data = empty ? '0 : mem[rd_ptr][WIDTH-1:0];
    assign head_func = empty ? '0 : mem[rd_ptr][WIDTH+2:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            // held requests must not fire on the first edge after reset
            push_d    <= 1'b1;
            pop_d     <= 1'b1;
        end else begin
            push_d <= push;
            pop_d  <= pop;
            if (push_ok) begin
                wr_ptr    <= wr_ptr + AW'(1);
                last_data <= ALUout;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_ev && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop_ev && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= {func, ALUout};
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// tb/tb_alu_result_queue.sv - scoreboard bench for alu_result_queue against a queue model
module tb_alu_result_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    typedef logic [WIDTH+2:0] ent_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] ALUout = '0;
    logic [2:0]       func = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] head_data;
    logic [2:0]       head_func;
    logic [WIDTH-1:0] last_data;
    logic [2:0]       count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int tests = 0;
    int fails = 0;

    ent_t             model_q[$];
    ent_t             exp_q[$];
    logic             m_ovf;
    logic             m_unf;
    logic [WIDTH-1:0] m_last;
    logic             m_push_prev;
    logic             m_pop_prev;

    alu_result_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .ALUout(ALUout), .func(func),
        .push(push), .pop(pop), .head_data(head_data), .head_func(head_func),
        .last_data(last_data), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Applies one cycle of inputs, advances the model, then checks the state after the edge.
    task automatic cyc(input logic r, input logic p, input logic po,
                       input logic [WIDTH-1:0] d, input logic [2:0] f);
        logic pe, oe, was_full, was_empty;
        reset = r; push = p; pop = po; ALUout = d; func = f;
        if (r) begin
            model_q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_last = '0;
            m_push_prev = 1'b1; m_pop_prev = 1'b1;
        end else begin
            pe = p && !m_push_prev;
            oe = po && !m_pop_prev;
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            if (oe) begin
                if (was_empty) m_unf = 1'b1;
                else exp_q.push_back(model_q.pop_front());
            end
            if (pe) begin
                if (!was_full || oe) begin
                    model_q.push_back({f, d});
                    m_last = d;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_push_prev = p;
            m_pop_prev  = po;
        end
        @(posedge clk);
        #1;
        chk("count", count, model_q.size());
        chk("empty", empty, model_q.size() == 0);
        chk("full", full, model_q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
        chk("last_data", last_data, m_last);
        chk("head_data", head_data, model_q.size() != 0 ? model_q[0][WIDTH-1:0] : 0);
        chk("head_func", head_func, model_q.size() != 0 ? model_q[0][WIDTH+2:WIDTH] : 0);
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d, input logic [2:0] f);
        cyc(1'b0, 1'b1, 1'b0, d, f);
        cyc(1'b0, 1'b0, 1'b0, '0, 3'd0);
    endtask

    task automatic do_pop();
        cyc(1'b0, 1'b0, 1'b1, '0, 3'd0);
        cyc(1'b0, 1'b0, 1'b0, '0, 3'd0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, '0, 3'd0);
    endtask

    // Monitor: on every pop edge the DUT sees while non-empty, the head must be the next expected entry.
    initial begin : monitor
        logic mon_pop_prev;
        ent_t e;
        mon_pop_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_pop_prev = 1'b1;
            end else begin
                if (pop && !mon_pop_prev && !empty) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_unexpected", {head_func, head_data}, 32'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_data", head_data, e[WIDTH-1:0]);
                        chk("pop_func", head_func, e[WIDTH+2:WIDTH]);
                    end
                end
                mon_pop_prev = pop;
            end
        end
    end

    initial begin : driver
        @(posedge clk);
        #1;
        // request held through reset must not fire
        cyc(1'b1, 1'b1, 1'b0, 8'h99, 3'd5);
        cyc(1'b0, 1'b1, 1'b0, 8'h99, 3'd5);
        cyc(1'b0, 1'b1, 1'b0, 8'h99, 3'd5);
        cyc(1'b0, 1'b0, 1'b0, '0, 3'd0);
        do_push(8'h15, 3'd0);
        do_pop();

        // fill, overflow, drain
        do_reset();
        do_push(8'h11, 3'd1);
        do_push(8'h22, 3'd2);
        do_push(8'h33, 3'd3);
        do_push(8'h44, 3'd4);
        do_push(8'h55, 3'd5);
        repeat (4) do_pop();

        // simultaneous push/pop while full
        do_reset();
        do_push(8'h11, 3'd1);
        do_push(8'h22, 3'd2);
        do_push(8'h33, 3'd3);
        do_push(8'h44, 3'd4);
        cyc(1'b0, 1'b1, 1'b1, 8'hAA, 3'd6);
        cyc(1'b0, 1'b0, 1'b0, '0, 3'd0);
        repeat (4) do_pop();

        // underflow, then simultaneous push/pop while empty
        do_pop();
        cyc(1'b0, 1'b1, 1'b1, 8'h07, 3'd7);
        cyc(1'b0, 1'b0, 1'b0, '0, 3'd0);
        do_pop();

        // wrap-around
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_push(WIDTH'(8'h60 + i), 3'(i));
            cyc(1'b0, 1'b0, 1'b0, '0, 3'd0);
            do_pop();
        end

        // reset mid-sequence
        do_reset();
        do_push(8'h01, 3'd1);
        do_push(8'h02, 3'd2);
        do_push(8'h03, 3'd3);
        do_push(8'h04, 3'd4);
        do_push(8'h05, 3'd5);
        do_pop();
        do_reset();
        exp_q.delete();
        do_push(8'hC3, 3'd2);

        // random levels, occasional reset
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                WIDTH'($urandom), 3'($urandom));
        end

        cyc(1'b0, 1'b0, 1'b0, '0, 3'd0);
        cyc(1'b0, 1'b0, 1'b0, '0, 3'd0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
